// File: rtl/dft_out_serializer_if.sv
// Stream-side bundle for dft_out_serializer: DFT frame input, word stream output, status.
// master = producer/consumer environment, slave = serializer.
interface dft_out_serializer_if #(
   parameter int WIDTH = 8,
   parameter int NPTS  = 8
);
   logic                    next_out;
   logic [NPTS*WIDTH-1:0]   y_in;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_first;
   logic                    out_last;
   logic                    overflow;
   logic                    busy;

   modport master (
      output next_out, y_in, out_ready,
      input  out_data, out_valid, out_first, out_last, overflow, busy
   );

   modport slave (
      input  next_out, y_in, out_ready,
      output out_data, out_valid, out_first, out_last, overflow, busy
   );
endinterface

// File: rtl/dft_out_serializer.sv
// Captures DFT core output frames into a DEPTH-frame buffer and streams them word by word.
// Define DFT_SER_CHECKSUM_EN to append a mod-2^WIDTH checksum word to every frame.
module dft_out_serializer #(
   parameter int WIDTH = 8,
   parameter int NPTS  = 8,
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dft_out_serializer_if.slave   bus
);
`ifdef DFT_SER_CHECKSUM_EN
   localparam int NW = NPTS + 1;
`else
   localparam int NW = NPTS;
`endif
   localparam int IDXW = $clog2(NW);
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW   = $clog2(DEPTH) + 1;
   localparam logic [IDXW-1:0] LASTIDX = IDXW'(NW - 1);
   localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
   localparam logic [PW-1:0]   PTR_MAX = PW'(DEPTH - 1);

   logic [NW-1:0][WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]            r_wr, r_rd;
   logic [CW-1:0]            r_cnt;
   logic [IDXW-1:0]          r_idx;
   logic                     r_cap_pend;
   logic                     r_ovf;

   logic                     w_valid, w_xfer, w_pop, w_full, w_cap, w_drop;
   logic [NW-1:0][WIDTH-1:0] w_frame;
`ifdef DFT_SER_CHECKSUM_EN
   logic [WIDTH-1:0]         w_sum;
`endif

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PTR_MAX) ? '0 : p + 1'b1;
   endfunction

   assign w_valid = (r_cnt != '0);
   assign w_xfer  = w_valid && bus.out_ready;
   assign w_pop   = w_xfer && (r_idx == LASTIDX);
   assign w_full  = (r_cnt == FULL);
   // A full buffer still accepts when the head frame leaves on the same edge.
   assign w_cap   = r_cap_pend && (!w_full || w_pop);
   assign w_drop  = r_cap_pend && w_full && !w_pop;

   always_comb begin
      w_frame = '0;
      for (int k = 0; k < NPTS; k++) w_frame[k] = bus.y_in[k*WIDTH +: WIDTH];
`ifdef DFT_SER_CHECKSUM_EN
      w_sum = '0;
      for (int k = 0; k < NPTS; k++) w_sum = w_sum + bus.y_in[k*WIDTH +: WIDTH];
      w_frame[NPTS] = w_sum;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_cap_pend <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_cap_pend <= bus.next_out;
         if (w_cap)  r_wr  <= f_inc(r_wr);
         if (w_drop) r_ovf <= 1'b1;
         if (w_xfer) r_idx <= w_pop ? '0 : r_idx + 1'b1;
         if (w_pop)  r_rd  <= f_inc(r_rd);
         r_cnt <= r_cnt + CW'(w_cap) - CW'(w_pop);
      end
   end

   // Frame storage needs no reset: nothing is read while the count is zero.
   always_ff @(posedge clk) begin
      if (w_cap) r_mem[r_wr] <= w_frame;
   end

   assign bus.out_valid = w_valid;
   assign bus.out_data  = w_valid ? r_mem[r_rd][r_idx] : '0;
   assign bus.out_first = w_valid && (r_idx == '0);
   assign bus.out_last  = w_valid && (r_idx == LASTIDX);
   assign bus.overflow  = r_ovf;
   assign bus.busy      = r_cap_pend || w_valid;
endmodule

// File: tb/tb_dft_out_serializer.sv
// Directed bench for dft_out_serializer; expected words are hand-computed frame constants.
module tb_dft_out_serializer;
   localparam int WIDTH = 8;
   localparam int NPTS  = 8;
   localparam int DEPTH = 2;
`ifdef DFT_SER_CHECKSUM_EN
   localparam int NW = NPTS + 1;
`else
   localparam int NW = NPTS;
`endif

   // {Y7..Y0}
   localparam logic [63:0] F1 = 64'hF800FCFC00F8100C;  // checksum 04
   localparam logic [63:0] F2 = 64'hF800FCFC00F8302C;  // checksum 44
   localparam logic [63:0] F3 = 64'h0102030405060708;  // checksum 24

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dft_out_serializer_if #(.WIDTH(WIDTH), .NPTS(NPTS)) bus ();

   dft_out_serializer #(.WIDTH(WIDTH), .NPTS(NPTS), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] wexp(input logic [63:0] f, input logic [7:0] cs, input int k);
      return (k < NPTS) ? f[k*8 +: 8] : cs;
   endfunction

   task automatic chk_word(input string tag, input logic [63:0] f, input logic [7:0] cs, input int k);
      chk($sformatf("%s_data%0d", tag, k), bus.out_data, wexp(f, cs, k));
      chk($sformatf("%s_vld%0d", tag, k), bus.out_valid, 1);
      chk($sformatf("%s_first%0d", tag, k), bus.out_first, (k == 0));
      chk($sformatf("%s_last%0d", tag, k), bus.out_last, (k == NW - 1));
   endtask

   // Call at the negedge where word 0 is visible; returns one negedge past the last word.
   task automatic expect_frame(input string tag, input logic [63:0] f, input logic [7:0] cs);
      for (int k = 0; k < NW; k++) begin
         chk_word(tag, f, cs, k);
         @(negedge clk);
      end
   endtask

   task automatic pulse(input logic [63:0] f);
      bus.next_out = 1'b1;
      bus.y_in     = f;
      @(negedge clk);
      bus.next_out = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.next_out  = 1'b0;
      bus.y_in      = '0;
      bus.out_ready = 1'b1;

      // Reset state
      #1;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data",  bus.out_data, 0);
      chk("rst_first", bus.out_first, 0);
      chk("rst_last",  bus.out_last, 0);
      chk("rst_ovf",   bus.overflow, 0);
      chk("rst_busy",  bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single frame, ready held high
      pulse(F1);
      chk("t1_busy_pend", bus.busy, 1);
      chk("t1_vld_early", bus.out_valid, 0);
      @(negedge clk);
      expect_frame("t1", F1, 8'h04);
      chk("t1_vld_end", bus.out_valid, 0);
      chk("t1_busy_end", bus.busy, 0);

      // 2: back-to-back pulses; y_in follows next_out by one cycle
      bus.next_out = 1'b1; bus.y_in = F1;
      @(negedge clk);
      bus.y_in = F1;
      @(negedge clk);
      bus.next_out = 1'b0; bus.y_in = F2;
      expect_frame("t2a", F1, 8'h04);
      expect_frame("t2b", F2, 8'h44);
      chk("t2_vld_end", bus.out_valid, 0);
      chk("t2_ovf", bus.overflow, 0);

      // 3: three pulses against a stalled sink, third is dropped
      bus.out_ready = 1'b0;
      bus.next_out = 1'b1; bus.y_in = F1;
      @(negedge clk);
      bus.y_in = F1;
      @(negedge clk);
      bus.y_in = F2;
      @(negedge clk);
      bus.next_out = 1'b0; bus.y_in = F3;
      chk("t3_ovf_before", bus.overflow, 0);
      @(negedge clk);
      chk("t3_ovf_set", bus.overflow, 1);
      chk("t3_hold_data", bus.out_data, 8'h0C);
      chk("t3_hold_first", bus.out_first, 1);
      @(negedge clk);
      chk("t3_hold_data2", bus.out_data, 8'h0C);
      bus.out_ready = 1'b1;
      expect_frame("t3a", F1, 8'h04);
      expect_frame("t3b", F2, 8'h44);
      chk("t3_vld_end", bus.out_valid, 0);
      chk("t3_ovf_sticky", bus.overflow, 1);

      rst_n = 1'b0;
      @(negedge clk);
      chk("rst2_ovf", bus.overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 4: full buffer, capture lands on the pop of the head frame's last word
      bus.out_ready = 1'b0;
      bus.next_out = 1'b1; bus.y_in = F1;
      @(negedge clk);
      bus.y_in = F1;
      @(negedge clk);
      bus.next_out = 1'b0; bus.y_in = F2;
      @(negedge clk);
      bus.out_ready = 1'b1;
      for (int j = 0; j < NW; j++) begin
         if (j == NW - 2) begin bus.next_out = 1'b1; bus.y_in = F3; end
         if (j == NW - 1) bus.next_out = 1'b0;
         chk_word("t4a", F1, 8'h04, j);
         @(negedge clk);
      end
      chk("t4_ovf", bus.overflow, 0);
      expect_frame("t4b", F2, 8'h44);
      expect_frame("t4c", F3, 8'h24);
      chk("t4_vld_end", bus.out_valid, 0);

      // 5: ready pattern 1,0,0 repeating
      pulse(F1);
      @(negedge clk);
      k = 0;
      for (int cyc = 0; cyc < 60 && k < NW; cyc++) begin
         chk_word("t5", F1, 8'h04, k);
         bus.out_ready = (cyc % 3 == 0);
         @(negedge clk);
         if (bus.out_ready) k++;
      end
      chk("t5_count", k, NW);
      chk("t5_vld_end", bus.out_valid, 0);
      bus.out_ready = 1'b1;

      // 6: async reset during word 3
      pulse(F1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk_word("t6", F1, 8'h04, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_vld", bus.out_valid, 0);
      chk("t6_data", bus.out_data, 0);
      chk("t6_first", bus.out_first, 0);
      chk("t6_last", bus.out_last, 0);
      chk("t6_busy", bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t6_idle", bus.out_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dft_out_serializer.md
Name: dft_out_serializer

Overview:
- Sits at the output end of the 8-point DFT core and consumes its parallel result frames.
- When the core pulses next_out, the block captures all NPTS words on the following clock edge into a small frame buffer.
- It then streams the buffered words out one word per transfer, Y0 first, under a valid/ready handshake with first/last markers.
- This decouples the core's one-frame-per-cycle burst output from narrow downstream consumers.

Parameters:
- WIDTH, 8, bits per output word.
- NPTS, 8, words per frame. Power of two, ≥2.
- DEPTH, 2, frames buffered. Power of two, ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- next_out  in  1  frame marker from the DFT core; the frame is valid on the edge after the one where next_out is sampled high.
- y_in  in  NPTS*WIDTH  core outputs concatenated; Y0 in bits [WIDTH-1:0], Yk in bits [(k+1)*WIDTH-1 : k*WIDTH].
- out_data  out  WIDTH  current stream word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts; a transfer happens on an edge where out_valid && out_ready.
- out_first  out  1  current word is word 0 of a frame.
- out_last  out  1  current word is the final word of a frame.
- overflow  out  1  sticky flag: a frame was dropped.
- busy  out  1  a capture is pending or the buffer is non-empty.

Behaviour:
- Reset (async, rst_n low):
  - out_valid, out_first, out_last, overflow, busy = 0; out_data = 0.
  - Buffer count, read/write pointers, word index and capture-pending flag = 0.
  - Reset asserted mid-stream discards all buffered frames and any partially sent frame. No output is ever resumed after reset.
- Capture:
  - The cap_pend register is loaded with next_out each edge.
  - On an edge where cap_pend = 1, y_in is written to the frame slot at wr_ptr, provided count < DEPTH or the same edge pops the last word of the head frame.
  - Back-to-back next_out pulses (edges N and N+1) capture on edges N+1 and N+2 as independent frames.
- Overflow:
  - A capture with the buffer full and no simultaneous frame pop is dropped: wr_ptr and count are unchanged, and overflow is set to 1.
  - overflow stays at 1 until reset.
- Stream:
  - out_valid = (count != 0), registered.
  - out_data = word[idx] of the head frame.
  - out_first = valid && idx == 0.
  - out_last = valid && idx == LASTIDX, where LASTIDX = NPTS-1, or NPTS with the optional feature enabled.
  - Each transfer increments idx.
  - A transfer with idx == LASTIDX sets idx to 0, advances rd_ptr (wrapping modulo DEPTH) and decrements count.
  - Capture and pop on the same edge leave count unchanged.
- Timing:
  - next_out sampled high at edge N: the frame is captured at N+1, and out_valid and word 0 are visible after N+1.
  - With out_ready held at 1, word k transfers at edge N+2+k.
  - Minimum output gap between frames: 0 cycles.
- Stall: while out_ready = 0, out_data, out_first and out_last hold stable. out_valid never deasserts mid-frame.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide.
- busy = cap_pend || (count != 0).

Optional Feature:
- Macro: DFT_SER_CHECKSUM_EN.
- Defined:
  - Each frame emits NPTS+1 words.
  - The extra final word is the mod-2^WIDTH sum of the NPTS frame words, computed at capture time and stored with the frame.
  - out_last marks the checksum word.
- Undefined:
  - No checksum storage.
  - Frames emit exactly NPTS words, and out_last marks Y(NPTS-1).

Test Plan:
1. Reset, then next_out pulse with y_in = {F8,00,FC,FC,00,F8,10,0C} (Y7..Y0) and out_ready = 1:
   - Stream is 0C 10 F8 00 FC FC 00 F8 on edges N+2..N+9.
   - out_first on 0C, out_last on F8.
   - With CHECKSUM_EN, a 9th word 04 carries out_last.
2. Two pulses 1 cycle apart, frames as in (1) and then 2C 30 F8 00 FC FC 00 F8, out_ready = 1:
   - 16 contiguous words with no gap and overflow = 0.
   - The second frame's checksum is 44.
3. out_ready = 0 while 3 pulses arrive (DEPTH = 2):
   - The third frame is dropped and overflow = 1.
   - Releasing out_ready yields exactly frames 1 and 2.
4. Buffer full, out_ready = 1, and a pulse timed so its capture coincides with the pop of the last word of the head frame:
   - The frame is accepted, count is unchanged and overflow stays 0.
5. out_ready toggled 1,0,0,1,... during a frame:
   - out_data is held stable across stalls and no word is duplicated or skipped.
6. rst_n asserted low asynchronously during word 3 of a frame:
   - Outputs go to 0 immediately.
   - After release with no next_out, out_valid stays 0.
